vmac_stream_ctrl: RTL and testbench

Parametrised streaming controller for the vectored FP MAC datapath. On a start request it sweeps a window of vector addresses in the A/B/C operand memories, unpacks each wide word into per-lane operands for an external `vector_mac`, and writes the packed results back to the output memory at the same address. It replaces the free-running address counter with a bounded, handshaked, latency-aligned pipeline.

---
 rtl/vmac_stream_ctrl_pkg.sv | 31 +++
 rtl/vmac_stream_ctrl_delay_line.sv | 28 ++
 rtl/vmac_stream_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_vmac_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmac_stream_ctrl_pkg.sv
// vmac_pkg: shared types and helpers for the vectored MAC streaming controller.
// Holds the sweep FSM state encoding and the width/latency helpers used to
// size the operand words and the valid/address pipeline.
package vmac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vmac_state_t;

  localparam int unsigned DEF_VECTOR  = 16;
  localparam int unsigned DEF_I_WIDTH = 32;
  localparam int unsigned DEF_RD_LAT  = 1;
  localparam int unsigned DEF_MAC_LAT = 0;

  // Packed vector word width and read-to-write latency for the default build.
  localparam int unsigned VLEN     = DEF_VECTOR * DEF_I_WIDTH;
  localparam int unsigned PIPE_LAT = DEF_RD_LAT + DEF_MAC_LAT + 1;

  // Parametric forms of the helpers above, for non-default instances.
  function automatic int unsigned vlen_of(input int unsigned vector, input int unsigned i_width);
    return vector * i_width;
  endfunction

  function automatic int unsigned pipe_lat_of(input int unsigned rd_lat, input int unsigned mac_lat);
    return rd_lat + mac_lat + 1;
  endfunction

endpackage

// File: rtl/vmac_stream_ctrl_delay_line.sv
// vmac_delay_line: fixed-depth shift register (DEPTH >= 1) with a synchronous
// active-low clear. Carries valid+address (and optionally the c operand) so
// that every write lines up with the read that produced it.
module vmac_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vmac_stream_ctrl.sv
// vmac_stream_ctrl: sweeps a window of vector addresses, streams operands to
// an external vector_mac and writes the results back at the same address.
// Optional feature macro: VMAC_LANE_MASK_EN (per-lane write mask; masked-off
// lanes write back their c operand unchanged).
module vmac_stream_ctrl
  import vmac_pkg::*;
#(
  parameter int VECTOR  = 16,
  parameter int I_WIDTH = 32,
  parameter int ADDR_W  = 7,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W:0]             length,
`ifdef VMAC_LANE_MASK_EN
  input  logic [VECTOR-1:0]           lane_mask,
`endif
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [VECTOR*I_WIDTH-1:0]   a_in,
  input  logic [VECTOR*I_WIDTH-1:0]   b_in,
  input  logic [VECTOR*I_WIDTH-1:0]   c_in,
  output logic [VECTOR*I_WIDTH-1:0]   mac_a,
  output logic [VECTOR*I_WIDTH-1:0]   mac_b,
  output logic [VECTOR*I_WIDTH-1:0]   mac_c,
  output logic                        mac_valid,
  input  logic [VECTOR*I_WIDTH-1:0]   mac_out,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [VECTOR*I_WIDTH-1:0]   wr_data
);

  localparam int VL         = int'(vlen_of(VECTOR, I_WIDTH));
  localparam int PL         = int'(pipe_lat_of(RD_LAT, MAC_LAT));
  localparam int MAC_STAGES = PL - RD_LAT;

  localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] CNT_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  vmac_state_t           state_r, next_state_s;
  logic [ADDR_W:0]       remain_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [ADDR_W+1:0]     inflight_r;
  logic                  busy_s, done_s, issue_s;
  logic                  accept_s;
  logic [ADDR_W:0]       rd_tap_s;
  logic [ADDR_W:0]       wr_tap_s;
  logic [VL-1:0]         wr_next_s;

  assign accept_s = (state_r == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic: issue for length cycles, then drain the pipeline.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (length == '0) next_state_s = DONE;
          else              next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (remain_r == REM_ONE) next_state_s = DRAIN;
        else                     next_state_s = ISSUE;
      end
      DRAIN: begin
        if (inflight_r == '0) next_state_s = DONE;
        else                  next_state_s = DRAIN;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the strobes can be registered.
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    issue_s = 1'b0;
    case (next_state_s)
      IDLE:    busy_s = 1'b0;
      ISSUE:   begin busy_s = 1'b1; issue_s = 1'b1; end
      DRAIN:   busy_s = 1'b1;
      DONE:    begin busy_s = 1'b1; done_s = 1'b1; end
      default: busy_s = 1'b0;
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      busy  <= busy_s;
      done  <= done_s;
      rd_en <= issue_s;
    end
  end

  // Sweep address and remaining-count tracking; address wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_r   <= '0;
      remain_r <= '0;
    end else if (accept_s && (length != '0)) begin
      addr_r   <= base_addr;
      remain_r <= length;
    end else if (state_r == ISSUE) begin
      addr_r   <= addr_r + ADR_ONE;
      remain_r <= remain_r - REM_ONE;
    end else begin
      addr_r   <= addr_r;
      remain_r <= remain_r;
    end
  end

  assign rd_addr = addr_r;

  // Vectors read but not yet written; a read and write together cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_r <= '0;
    end else begin
      case ({rd_en, wr_en})
        2'b10:   inflight_r <= inflight_r + CNT_ONE;
        2'b01:   inflight_r <= inflight_r - CNT_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Valid+address: read -> operand stage (RD_LAT), then -> write (MAC_LAT+1).
  vmac_delay_line #(.WIDTH(ADDR_W+1), .DEPTH(RD_LAT)) u_rd_dly (
    .clk(clk), .reset(reset), .din({rd_en, rd_addr}), .dout(rd_tap_s)
  );

  vmac_delay_line #(.WIDTH(ADDR_W+1), .DEPTH(MAC_STAGES)) u_wr_dly (
    .clk(clk), .reset(reset), .din(rd_tap_s), .dout(wr_tap_s)
  );

  assign mac_valid = rd_tap_s[ADDR_W];
  assign wr_en     = wr_tap_s[ADDR_W];
  assign wr_addr   = wr_tap_s[ADDR_W-1:0];

`ifdef VMAC_LANE_MASK_EN
  logic [VECTOR-1:0] mask_r;
  logic [VL-1:0]     c_aligned_s;

  // Lane mask is captured together with the sweep parameters.
  always_ff @(posedge clk) begin
    if (!reset)        mask_r <= '0;
    else if (accept_s) mask_r <= lane_mask;
    else               mask_r <= mask_r;
  end

  // c operand delayed to arrive together with mac_out.
  vmac_delay_line #(.WIDTH(VL), .DEPTH(MAC_LAT+1)) u_c_dly (
    .clk(clk), .reset(reset), .din(c_in), .dout(c_aligned_s)
  );

  // Per-lane select between the MAC result and the untouched c operand.
  always_comb begin
    wr_next_s = '0;
    for (int i = 0; i < VECTOR; i++) begin
      if (mask_r[i]) wr_next_s[I_WIDTH*i +: I_WIDTH] = mac_out[I_WIDTH*i +: I_WIDTH];
      else           wr_next_s[I_WIDTH*i +: I_WIDTH] = c_aligned_s[I_WIDTH*i +: I_WIDTH];
    end
  end
`else
  // Every lane writes the MAC result.
  always_comb begin
    wr_next_s = mac_out;
  end
`endif

  // Registered operand and write-data paths.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mac_a   <= '0;
      mac_b   <= '0;
      mac_c   <= '0;
      wr_data <= '0;
    end else begin
      mac_a   <= a_in;
      mac_b   <= b_in;
      mac_c   <= c_in;
      wr_data <= wr_next_s;
    end
  end

endmodule

// File: tb/tb_vmac_stream_ctrl.sv
// tb_vmac_stream_ctrl: scoreboard bench for vmac_stream_ctrl. Expected reads,
// operand strobes, writes and done pulses are queued when a sweep is issued;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_vmac_stream_ctrl;

  localparam int VECTOR  = 16;
  localparam int I_WIDTH = 32;
  localparam int ADDR_W  = 7;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 0;
  localparam int VL      = VECTOR * I_WIDTH;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [VECTOR-1:0] mask_v;
  logic              busy, done, rd_en, mac_valid, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [VL-1:0]     a_in, b_in, c_in, mac_a, mac_b, mac_c, mac_out, wr_data;

  logic [VL-1:0] mem_a [DEPTH];
  logic [VL-1:0] mem_b [DEPTH];
  logic [VL-1:0] mem_c [DEPTH];

  typedef struct { int cyc; logic [ADDR_W-1:0] addr; } rd_t;
  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic [VL-1:0] data; } wr_t;

  rd_t rd_q[$];
  int  mv_q[$];
  wr_t wr_q[$];
  int  done_q[$];
  rd_t mon_r;
  wr_t mon_w;
  int  mon_d;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  sw_start = -1;
  int  sw_done = -1;

  always #5 clk = ~clk;

  vmac_stream_ctrl #(
    .VECTOR(VECTOR), .I_WIDTH(I_WIDTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
`ifdef VMAC_LANE_MASK_EN
    .lane_mask(mask_v),
`endif
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_valid(mac_valid),
    .mac_out(mac_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Operand memories with one-cycle read latency into the operand register.
  assign a_in = mem_a[rd_addr];
  assign b_in = mem_b[rd_addr];
  assign c_in = mem_c[rd_addr];

  // Stand-in vector_mac: zero-latency integer a*b+c per lane.
  always_comb begin
    mac_out = '0;
    for (int i = 0; i < VECTOR; i++)
      mac_out[I_WIDTH*i +: I_WIDTH] = mac_a[I_WIDTH*i +: I_WIDTH] * mac_b[I_WIDTH*i +: I_WIDTH]
                                      + mac_c[I_WIDTH*i +: I_WIDTH];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: actual event present, required none", name, cyc);
  endtask

  // Reference result word for one address: masked-off lanes keep c.
  function automatic logic [VL-1:0] exp_word(input int addr, input logic [VECTOR-1:0] m);
    logic [VL-1:0]      w;
    logic [I_WIDTH-1:0] a, b, c;
    w = '0;
    for (int i = 0; i < VECTOR; i++) begin
      a = mem_a[addr][I_WIDTH*i +: I_WIDTH];
      b = mem_b[addr][I_WIDTH*i +: I_WIDTH];
      c = mem_c[addr][I_WIDTH*i +: I_WIDTH];
      w[I_WIDTH*i +: I_WIDTH] = m[i] ? (a * b + c) : c;
    end
    return w;
  endfunction

  // Monitor: compare every DUT event against the head of its queue.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_q.size() == 0) unexpected("rd_en");
      else begin
        mon_r = rd_q.pop_front();
        chk("rd_cycle", VL'(cyc), VL'(mon_r.cyc));
        chk("rd_addr", VL'(rd_addr), VL'(mon_r.addr));
      end
    end
    if (mac_valid) begin
      if (mv_q.size() == 0) unexpected("mac_valid");
      else chk("mac_valid_cycle", VL'(cyc), VL'(mv_q.pop_front()));
    end
    if (wr_en) begin
      if (wr_q.size() == 0) unexpected("wr_en");
      else begin
        mon_w = wr_q.pop_front();
        chk("wr_cycle", VL'(cyc), VL'(mon_w.cyc));
        chk("wr_addr", VL'(wr_addr), VL'(mon_w.addr));
        chk("wr_data", wr_data, mon_w.data);
      end
    end
    if (done) begin
      if (done_q.size() == 0) unexpected("done");
      else begin
        mon_d = done_q.pop_front();
        chk("done_cycle", VL'(cyc), VL'(mon_d));
      end
    end
    chk("busy", VL'(busy), VL'(sw_start >= 0 && cyc > sw_start && cyc <= sw_done));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++)
      for (int l = 0; l < VECTOR; l++) begin
        mem_a[i][I_WIDTH*l +: I_WIDTH] = I_WIDTH'($urandom);
        mem_b[i][I_WIDTH*l +: I_WIDTH] = I_WIDTH'($urandom);
        mem_c[i][I_WIDTH*l +: I_WIDTH] = I_WIDTH'($urandom);
      end
  endtask

  // Issue a start at the current cycle and queue everything it must produce.
  task automatic issue_sweep(input int base, input int len, input logic [VECTOR-1:0] m);
    int c0, addr;
    c0 = cyc;
    start = 1'b1;
    base_addr = ADDR_W'(base);
    length = (ADDR_W+1)'(len);
    mask_v = m;
    for (int k = 0; k < len; k++) begin
      addr = (base + k) % DEPTH;
      rd_q.push_back('{c0 + 1 + k, ADDR_W'(addr)});
      mv_q.push_back(c0 + 1 + k + RD_LAT);
      wr_q.push_back('{c0 + 2 + k + RD_LAT + MAC_LAT, ADDR_W'(addr), exp_word(addr, m)});
    end
    sw_start = c0;
    sw_done = (len == 0) ? c0 + 1 : c0 + len + RD_LAT + MAC_LAT + 3;
    done_q.push_back(sw_done);
    step();
    start = 1'b0;
  endtask

  task automatic wait_sweep();
    while (cyc <= sw_done + 1) step();
    repeat ($urandom_range(0, 3)) step();
  endtask

  task automatic check_zero();
    chk("rst_busy", VL'(busy), '0);
    chk("rst_done", VL'(done), '0);
    chk("rst_rd_en", VL'(rd_en), '0);
    chk("rst_rd_addr", VL'(rd_addr), '0);
    chk("rst_mac_valid", VL'(mac_valid), '0);
    chk("rst_mac_a", mac_a, '0);
    chk("rst_mac_b", mac_b, '0);
    chk("rst_mac_c", mac_c, '0);
    chk("rst_wr_en", VL'(wr_en), '0);
    chk("rst_wr_addr", VL'(wr_addr), '0);
    chk("rst_wr_data", wr_data, '0);
  endtask

  logic [VECTOR-1:0] all_on;
  logic [VECTOR-1:0] lo_half;
  int c_mark;

  initial begin
    all_on = '1;
    lo_half = 16'h00FF;
    reset = 1'b0; start = 1'b0; base_addr = '0; length = '0; mask_v = '1;
    fill_random();
    repeat (3) step();
    check_zero();
    reset = 1'b1;
    repeat (2) step();

    // Directed: a=k, b=2, c=1 -> every lane writes 2k+1.
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < VECTOR; l++) begin
        mem_a[k][I_WIDTH*l +: I_WIDTH] = I_WIDTH'(k);
        mem_b[k][I_WIDTH*l +: I_WIDTH] = 32'd2;
        mem_c[k][I_WIDTH*l +: I_WIDTH] = 32'd1;
      end
    issue_sweep(0, 4, all_on);
    wait_sweep();

    // Address wrap at the top of memory.
    issue_sweep(126, 4, all_on);
    wait_sweep();

    // Zero-length sweep: done next cycle, no traffic.
    issue_sweep(5, 0, all_on);
    wait_sweep();

    // A second start during a sweep is ignored.
    issue_sweep(40, 8, all_on);
    repeat (2) step();
    start = 1'b1; base_addr = 7'd90; length = 8'd2;
    step();
    start = 1'b0;
    wait_sweep();

    // Reset during DRAIN with two vectors in flight.
    issue_sweep(10, 6, all_on);
    c_mark = sw_start;
    while (cyc < c_mark + 6 + 1) step();
    reset = 1'b0;
    step();
    rd_q.delete(); mv_q.delete(); wr_q.delete(); done_q.delete();
    sw_start = -1; sw_done = -1;
    check_zero();
    reset = 1'b1;
    repeat (8) step();
    issue_sweep(20, 3, all_on);
    wait_sweep();

    // Randomised sweeps, including a full-memory sweep.
    fill_random();
    for (int s = 0; s < 8; s++) begin
      issue_sweep($urandom_range(0, DEPTH-1), $urandom_range(1, 24), all_on);
      wait_sweep();
    end
    issue_sweep($urandom_range(0, DEPTH-1), DEPTH, all_on);
    wait_sweep();

`ifdef VMAC_LANE_MASK_EN
    for (int k = 0; k < DEPTH; k++)
      for (int l = 0; l < VECTOR; l++) mem_c[k][I_WIDTH*l +: I_WIDTH] = 32'd7;
    issue_sweep(3, 5, lo_half);
    wait_sweep();
    fill_random();
    for (int s = 0; s < 3; s++) begin
      issue_sweep($urandom_range(0, DEPTH-1), $urandom_range(1, 10), VECTOR'($urandom));
      wait_sweep();
    end
`endif

    repeat (4) step();
    chk("queues_empty", VL'(rd_q.size() + mv_q.size() + wr_q.size() + done_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
